// File: rtl/decoder_pipe.sv
// Pipelined instruction decoder with valid/ready handshakes, a per-register busy
// scoreboard that stalls on RAW/WAW hazards, and an illegal-opcode flag.
module decoder_pipe #(
  parameter int DW    = 16,
  parameter int RW    = 3,
  parameter int IW    = 16,
  parameter int SB_EN = 1
) (
  input  logic             ck,
  input  logic             res,
  input  logic [IW-1:0]    INST,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             wb_valid,
  input  logic [RW-1:0]    wb_sel,
  output logic [3:0]       OP,
  output logic [RW-1:0]    LSEL,
  output logic [RW-1:0]    RSEL,
  output logic [RW-1:0]    OSEL,
  output logic             LOUT,
  output logic             ROUT,
  output logic             OIN,
  output logic [DW-1:0]    R,
  output logic             REN,
  output logic             ILL,
  output logic [2**RW-1:0] busy
);

  localparam int NREG  = 2**RW;
  localparam int IMM_W = IW - 4 - RW;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LOADI  = 4'h5;
  localparam logic [3:0] OP_LOADIS = 4'h6;
  localparam logic [3:0] OP_MOV    = 4'h7;

  logic [3:0]       op;
  logic [RW-1:0]    f_osel, f_lsel, f_rsel;
  logic [IMM_W-1:0] imm;

  assign op     = INST[IW-1 -: 4];
  assign f_osel = INST[IW-5 -: RW];
  assign f_lsel = INST[IW-5-RW -: RW];
  assign f_rsel = INST[IW-5-2*RW -: RW];
  assign imm    = INST[IMM_W-1:0];

  logic [3:0]    d_op;
  logic [RW-1:0] d_lsel, d_rsel, d_osel;
  logic          d_lout, d_rout, d_oin, d_ren, d_ill;
  logic [DW-1:0] d_r;

  always_comb begin
    d_op   = op;
    d_lsel = '0;
    d_rsel = '0;
    d_osel = '0;
    d_lout = 1'b0;
    d_rout = 1'b0;
    d_oin  = 1'b0;
    d_ren  = 1'b0;
    d_ill  = 1'b0;
    d_r    = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        d_lout = 1'b1;
        d_rout = 1'b1;
        d_oin  = 1'b1;
        d_lsel = f_lsel;
        d_rsel = f_rsel;
        d_osel = f_osel;
      end
      OP_LOADI: begin
        d_oin  = 1'b1;
        d_osel = f_osel;
        d_ren  = 1'b1;
        d_r    = DW'(imm);
      end
      OP_LOADIS: begin
        d_oin  = 1'b1;
        d_osel = f_osel;
        d_ren  = 1'b1;
        d_r    = DW'($signed(imm));
      end
      OP_MOV: begin
        // MOV is issued to the ALU as ADD with the right operand unused
        d_op   = OP_ADD;
        d_lout = 1'b1;
        d_oin  = 1'b1;
        d_lsel = f_lsel;
        d_osel = f_osel;
      end
      default: d_ill = 1'b1;
    endcase
  end

  logic [NREG-1:0] wb_mask, need, set_mask, busy_eff;
  logic            hazard, accept;

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_sel] = 1'b1;
    need = '0;
    if (d_lout) need[d_lsel] = 1'b1;
    if (d_rout) need[d_rsel] = 1'b1;
    if (d_oin)  need[d_osel] = 1'b1;
  end

  // A same-cycle writeback clears the bit before the hazard check (bypass)
  assign busy_eff = busy & ~wb_mask;
  assign hazard   = (SB_EN != 0) && !d_ill && (|(need & busy_eff));
  assign in_ready = (!out_valid || out_ready) && !hazard && res;
  assign accept   = in_valid && in_ready;

  always_comb begin
    set_mask = '0;
    if (accept && d_oin) set_mask[d_osel] = 1'b1;
  end

  logic [DW-1:0] r_q;

  always_ff @(posedge ck) begin
    if (!res) begin
      out_valid <= 1'b0;
      OP        <= '0;
      LSEL      <= '0;
      RSEL      <= '0;
      OSEL      <= '0;
      LOUT      <= 1'b0;
      ROUT      <= 1'b0;
      OIN       <= 1'b0;
      REN       <= 1'b0;
      ILL       <= 1'b0;
      r_q       <= '0;
      busy      <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        OP        <= d_op;
        LSEL      <= d_lsel;
        RSEL      <= d_rsel;
        OSEL      <= d_osel;
        LOUT      <= d_lout;
        ROUT      <= d_rout;
        OIN       <= d_oin;
        REN       <= d_ren;
        ILL       <= d_ill;
        r_q       <= d_r;
      end else if (out_ready && out_valid) begin
        out_valid <= 1'b0;
        LOUT      <= 1'b0;
        ROUT      <= 1'b0;
        OIN       <= 1'b0;
        REN       <= 1'b0;
        ILL       <= 1'b0;
      end
      busy <= busy_eff | set_mask;
    end
  end

  assign R = REN ? r_q : 'z;

endmodule
